// File: rtl/adc_az_sequencer_if.sv
// Host/ADC-side signal bundle for the auto-zero sequencer.
// The host and ADC side drive the master modport; the sequencer uses the slave modport.
interface adc_az_sequencer_if #(
    parameter int CNT_W = 24
);
    logic             run;
    logic             az_enable;
    logic [CNT_W-1:0] settle_duration;
    logic [31:0]      timeout_duration;
    logic             adc_measure_valid;
    logic             adc_measure_trig;
    logic [1:0]       azmux;
    logic             sample_done;
    logic             sample_phase;
    logic [15:0]      sample_count;
    logic             timeout_err;
    logic [5:0]       monitor;

    modport master (
        output run, az_enable, settle_duration, timeout_duration, adc_measure_valid,
        input  adc_measure_trig, azmux, sample_done, sample_phase, sample_count,
               timeout_err, monitor
    );

    modport slave (
        input  run, az_enable, settle_duration, timeout_duration, adc_measure_valid,
        output adc_measure_trig, azmux, sample_done, sample_phase, sample_count,
               timeout_err, monitor
    );
endinterface

// File: rtl/adc_az_sequencer.sv
// Auto-zero sequencer: selects signal/zero-reference mux phase, settles, triggers the ADC
// and reports each completed sample, optionally alternating HI/LO phases.
//
// state  | meaning
// IDLE   | mux parked, waiting for run
// SETTLE | mux driven for current phase, settle down-counter running
// TRIG   | single-cycle ADC trigger
// WAIT   | waiting for a rising edge of adc_measure_valid or timeout
// DONE   | sample completed, phase advanced
module adc_az_sequencer #(
    parameter int         CNT_W     = 24,
    parameter logic [1:0] AZMUX_SIG = 2'b01,
    parameter logic [1:0] AZMUX_LO  = 2'b10,
    parameter logic [1:0] AZMUX_OFF = 2'b00
) (
    input logic             clk,
    input logic             reset,
    adc_az_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_TRIG   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_settle_cnt;
    logic [31:0]      r_tcnt;
    logic             r_phase;
    logic             r_valid_prev;
    logic             r_sample_phase;
    logic [15:0]      r_sample_count;
    logic             r_timeout_err;
    logic             w_valid_rise;
    logic             w_trig;
    logic             w_done;
    logic [1:0]       w_azmux;

    assign w_valid_rise = bus.adc_measure_valid & ~r_valid_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!bus.run) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_next = ST_SETTLE;
                ST_SETTLE: if (r_settle_cnt == '0) w_state_next = ST_TRIG;
                ST_TRIG:   w_state_next = ST_WAIT;
                ST_WAIT: begin
                    if (w_valid_rise) begin
                        w_state_next = ST_DONE;
                    end else if (r_tcnt <= 32'd1) begin
                        w_state_next = ST_SETTLE;
                    end
                end
                ST_DONE:   w_state_next = ST_SETTLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_azmux = AZMUX_OFF;
        w_trig  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE: w_azmux = AZMUX_OFF;
            ST_TRIG: begin
                w_azmux = r_phase ? AZMUX_LO : AZMUX_SIG;
                w_trig  = 1'b1;
            end
            ST_DONE: begin
                w_azmux = r_phase ? AZMUX_LO : AZMUX_SIG;
                w_done  = 1'b1;
            end
            default: w_azmux = r_phase ? AZMUX_LO : AZMUX_SIG;
        endcase
    end

    // The timeout window is loaded on entry to TRIG so it counts from the trigger cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle_cnt <= '0;
            r_tcnt       <= '0;
            r_valid_prev <= 1'b0;
        end else begin
            r_valid_prev <= bus.adc_measure_valid;
            if (w_state_next == ST_SETTLE && r_state != ST_SETTLE) begin
                r_settle_cnt <= bus.settle_duration;
            end else if (r_state == ST_SETTLE && r_settle_cnt != '0) begin
                r_settle_cnt <= r_settle_cnt - 1'b1;
            end
            if (w_state_next == ST_TRIG && r_state != ST_TRIG) begin
                r_tcnt <= bus.timeout_duration;
            end else if ((r_state == ST_TRIG || r_state == ST_WAIT) && r_tcnt != 32'd0) begin
                r_tcnt <= r_tcnt - 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase        <= 1'b0;
            r_sample_phase <= 1'b0;
            r_sample_count <= 16'd0;
            r_timeout_err  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_phase <= 1'b0;
            end else if (r_state == ST_DONE) begin
                r_phase <= bus.az_enable ? ~r_phase : 1'b0;
            end
            // Sample results update on the edge into DONE so they line up with sample_done.
            if (r_state == ST_WAIT && w_state_next == ST_DONE) begin
                r_sample_phase <= r_phase;
                r_sample_count <= r_sample_count + 16'd1;
            end
            if (!bus.run) begin
                r_timeout_err <= 1'b0;
            end else if (r_state == ST_WAIT && w_state_next == ST_SETTLE) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign bus.adc_measure_trig = w_trig;
    assign bus.azmux            = w_azmux;
    assign bus.sample_done      = w_done;
    assign bus.sample_phase     = r_sample_phase;
    assign bus.sample_count     = r_sample_count;
    assign bus.timeout_err      = r_timeout_err;
    assign bus.monitor          = {r_state, r_phase, bus.adc_measure_valid, w_trig};
endmodule

// File: tb/tb_adc_az_sequencer.sv
// Directed bench for adc_az_sequencer with a small ADC response model.
module tb_adc_az_sequencer;
    localparam int CNT_W = 24;
    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_STALE  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    adc_az_sequencer_if #(.CNT_W(CNT_W)) bus ();

    adc_az_sequencer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int adc_mode = M_NORMAL;
    int lat = 10;
    logic stale_level = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_trig(input string tag, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.adc_measure_trig) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk({tag, " trig wait"}, 32'(bus.adc_measure_trig), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget, output int at,
                             output logic ph, output logic [15:0] cnt);
        at = -1;
        ph = 1'b0;
        cnt = 16'd0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.sample_done) begin
                at  = cyc;
                ph  = bus.sample_phase;
                cnt = bus.sample_count;
                break;
            end
        end
        if (at < 0) chk({tag, " done wait"}, 32'(bus.sample_done), 32'd1);
    endtask

    // ADC model: valid falls the cycle after a trigger and rises lat cycles after it.
    initial begin
        int  since;
        logic armed;
        since = 0;
        armed = 1'b0;
        bus.adc_measure_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                bus.adc_measure_valid = 1'b0;
                armed = 1'b0;
            end else if (adc_mode == M_NORMAL) begin
                if (bus.adc_measure_trig) begin
                    since = 0;
                    armed = 1'b1;
                end else if (armed) begin
                    since++;
                    bus.adc_measure_valid = (since >= lat);
                end
            end else if (adc_mode == M_NEVER) begin
                bus.adc_measure_valid = 1'b0;
            end else begin
                bus.adc_measure_valid = stale_level;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, summary %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int rs, t0, t1, t2, tp, d, e, pulses;
        logic ph;
        logic [15:0] cnt;

        bus.run = 1'b0;
        bus.az_enable = 1'b0;
        bus.settle_duration = 24'd3;
        bus.timeout_duration = 32'd1000;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst azmux", 32'(bus.azmux), 32'd0);
        chk("rst count", 32'(bus.sample_count), 32'd0);
        chk("rst outputs", 32'({bus.adc_measure_trig, bus.sample_done, bus.sample_phase,
                                bus.timeout_err}), 32'd0);
        chk("rst monitor", 32'(bus.monitor), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: HI only, settle 3, latency 10
        rs = cyc;
        bus.run = 1'b1;
        wait_trig("t1 first", 20, t0);
        chk("t1 first trig", 32'(t0 - rs), 32'd5);
        chk("t1 azmux", 32'(bus.azmux), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            wait_done("t1", 40, d, ph, cnt);
            chk("t1 done latency", 32'(d - t0), 32'd11);
            chk("t1 phase", 32'(ph), 32'd0);
            chk("t1 count", 32'(cnt), 32'(i));
            wait_trig("t1", 40, t1);
            chk("t1 period", 32'(t1 - t0), 32'd16);
            chk("t1 azmux", 32'(bus.azmux), 32'd1);
            t0 = t1;
        end
        bus.run = 1'b0;
        repeat (2) @(negedge clk);

        // 2: alternate phases, settle 0
        bus.az_enable = 1'b1;
        bus.settle_duration = 24'd0;
        lat = 2;
        rs = cyc;
        bus.run = 1'b1;
        wait_trig("t2 first", 20, t0);
        chk("t2 first trig", 32'(t0 - rs), 32'd2);
        chk("t2 azmux first", 32'(bus.azmux), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_done("t2", 20, d, ph, cnt);
            chk("t2 done latency", 32'(d - t0), 32'd3);
            chk("t2 phase", 32'(ph), 32'(i % 2));
            wait_trig("t2", 20, t1);
            chk("t2 period", 32'(t1 - t0), 32'd5);
            chk("t2 azmux", 32'(bus.azmux), ((i + 1) % 2 == 1) ? 32'd2 : 32'd1);
            t0 = t1;
        end
        bus.run = 1'b0;
        repeat (2) @(negedge clk);

        // 3: timeout in the LO phase, retry keeps LO
        bus.settle_duration = 24'd3;
        bus.timeout_duration = 32'd20;
        lat = 10;
        bus.run = 1'b1;
        wait_trig("t3 hi", 20, t0);
        wait_done("t3 hi", 40, d, ph, cnt);
        chk("t3 hi phase", 32'(ph), 32'd0);
        adc_mode = M_NEVER;
        wait_trig("t3 lo", 20, t1);
        chk("t3 lo azmux", 32'(bus.azmux), 32'd2);
        e = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.timeout_err) begin
                e = cyc;
                break;
            end
        end
        chk("t3 err time", 32'(e - t1), 32'd20);
        wait_trig("t3 retry", 20, t2);
        chk("t3 retry delay", 32'(t2 - t1), 32'd24);
        chk("t3 retry azmux", 32'(bus.azmux), 32'd2);
        chk("t3 err sticky", 32'(bus.timeout_err), 32'd1);
        bus.run = 1'b0;
        @(negedge clk);
        chk("t3 err clear", 32'(bus.timeout_err), 32'd0);
        chk("t3 idle azmux", 32'(bus.azmux), 32'd0);
        @(negedge clk);

        // 4: valid held high across the trigger
        bus.az_enable = 1'b0;
        bus.settle_duration = 24'd0;
        bus.timeout_duration = 32'd1000;
        stale_level = 1'b1;
        adc_mode = M_STALE;
        @(negedge clk);
        bus.run = 1'b1;
        wait_trig("t4", 20, t0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pulses += int'(bus.sample_done);
        end
        chk("t4 stale no done", 32'(pulses), 32'd0);
        stale_level = 1'b0;
        @(negedge clk);
        stale_level = 1'b1;
        rs = cyc;
        wait_done("t4", 20, d, ph, cnt);
        chk("t4 done after edge", 32'(d - rs), 32'd2);
        chk("t4 count", 32'(cnt), 32'd9);
        bus.run = 1'b0;
        repeat (2) @(negedge clk);

        // 5: abort in WAIT and in SETTLE
        adc_mode = M_NORMAL;
        bus.az_enable = 1'b1;
        bus.settle_duration = 24'd5;
        rs = cyc;
        bus.run = 1'b1;
        wait_trig("t5", 30, t0);
        chk("t5 first trig", 32'(t0 - rs), 32'd7);
        repeat (3) @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        chk("t5 wait abort state", 32'(bus.monitor[5:3]), 32'd0);
        chk("t5 wait abort azmux", 32'(bus.azmux), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pulses += int'(bus.sample_done) + int'(bus.adc_measure_trig);
        end
        chk("t5 no pulses", 32'(pulses), 32'd0);
        chk("t5 count kept", 32'(bus.sample_count), 32'd9);
        bus.run = 1'b1;
        @(negedge clk);
        chk("t5 restart state", 32'(bus.monitor[5:3]), 32'd1);
        chk("t5 restart azmux", 32'(bus.azmux), 32'd1);
        repeat (2) @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        chk("t5 settle abort", 32'({bus.monitor[5:3], bus.azmux}), 32'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pulses += int'(bus.adc_measure_trig);
        end
        chk("t5 no trig", 32'(pulses), 32'd0);

        // 6: count wrap, then async reset mid-WAIT
        bus.settle_duration = 24'd0;
        bus.run = 1'b1;
        wait_trig("t6", 20, t0);
        @(negedge clk);
        force dut.r_sample_count = 16'hFFFF;
        #1;
        release dut.r_sample_count;
        chk("t6 preload", 32'(bus.sample_count), 32'h0000_FFFF);
        wait_done("t6 wrap", 30, d, ph, cnt);
        chk("t6 wrap count", 32'(cnt), 32'd0);
        chk("t6 wrap flag", 32'(bus.timeout_err), 32'd0);
        wait_trig("t6 b", 20, t1);
        wait_done("t6 b", 30, d, ph, cnt);
        chk("t6 after wrap", 32'({cnt, 15'd0, ph}), 32'h0001_0001);
        wait_trig("t6 c", 20, t2);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6 reset azmux", 32'(bus.azmux), 32'd0);
        chk("t6 reset count", 32'(bus.sample_count), 32'd0);
        chk("t6 reset flags", 32'({bus.adc_measure_trig, bus.sample_done, bus.sample_phase,
                                   bus.timeout_err}), 32'd0);
        chk("t6 reset monitor", 32'({bus.monitor[5:2], bus.monitor[0]}), 32'd0);
        bus.run = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
